// File: rtl/m31_partial_round_sched.sv
// Iterative sequencer: runs one Poseidon2 state through N_ROUNDS M31 partial
// rounds on a shared pipelined datapath (latency PR_LATENCY).
// Ports: clk, rst_n (sync, active-low); in_valid_i/in_ready_o/in_state_i job
// input; rc_idx_o/rc_i constant ROM; dp_state_o/dp_const_o/dp_state_i to and
// from the datapath; out_valid_o/out_ready_i/out_state_o result; busy_o,
// round_o status. Optional macro M31_SCHED_ABORT_EN adds abort_i.
module m31_partial_round_sched #(
  parameter int WIDTH      = 16,
  parameter int N_ROUNDS   = 14,
  parameter int PR_LATENCY = 13,
  localparam int SW = WIDTH * 31,
  localparam int RW = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1,
  localparam int CW = $clog2(PR_LATENCY) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef M31_SCHED_ABORT_EN
  input  logic          abort_i,
`endif
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [SW-1:0] in_state_i,
  output logic [RW-1:0] rc_idx_o,
  input  logic [30:0]   rc_i,
  output logic [SW-1:0] dp_state_o,
  output logic [30:0]   dp_const_o,
  input  logic [SW-1:0] dp_state_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [SW-1:0] out_state_o,
  output logic          busy_o,
  output logic [RW-1:0] round_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] work_q, work_d;
  logic [RW-1:0] round_q, round_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      round_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          work_d  = in_state_i;
          round_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(PR_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Datapath result for this round is valid only now.
          work_d = dp_state_i;
          if (round_q == RW'(N_ROUNDS - 1)) begin
            state_d = DONE;
          end else begin
            round_d = round_q + RW'(1);
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef M31_SCHED_ABORT_EN
    // Abort wins over capture and the output handshake.
    if (abort_i && (state_q != IDLE)) state_d = IDLE;
`endif
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_state_o = work_q;
  assign dp_state_o  = work_q;
  assign dp_const_o  = rc_i;
  assign rc_idx_o    = round_q;
  assign round_o     = round_q;

endmodule

// File: tb/tb_m31_partial_round_sched.sv
// Scoreboard bench for m31_partial_round_sched with a latency-accurate
// M31 partial-round datapath model and constant ROM model.
module tb_m31_partial_round_sched;

  localparam int W   = 16;
  localparam int NR  = 14;
  localparam int PL  = 13;
  localparam int SW  = W * 31;
  localparam int RW  = $clog2(NR);
  localparam int LAT = 1 + NR * (PL + 1);
  localparam logic [31:0] P = 32'h7fff_ffff;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid_i = 0;
  logic          in_ready_o;
  logic [SW-1:0] in_state_i = '0;
  logic [RW-1:0] rc_idx_o;
  logic [30:0]   rc_i;
  logic [SW-1:0] dp_state_o;
  logic [30:0]   dp_const_o;
  logic [SW-1:0] dp_state_i;
  logic          out_valid_o;
  logic          out_ready_i = 1;
  logic [SW-1:0] out_state_o;
  logic          busy_o;
  logic [RW-1:0] round_o;
`ifdef M31_SCHED_ABORT_EN
  logic          abort_i = 0;
`endif

  bit zero_rc = 1;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  m31_partial_round_sched #(
    .WIDTH(W), .N_ROUNDS(NR), .PR_LATENCY(PL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef M31_SCHED_ABORT_EN
    .abort_i(abort_i),
`endif
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_state_i(in_state_i),
    .rc_idx_o(rc_idx_o),
    .rc_i(rc_i),
    .dp_state_o(dp_state_o),
    .dp_const_o(dp_const_o),
    .dp_state_i(dp_state_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_state_o(out_state_o),
    .busy_o(busy_o),
    .round_o(round_o)
  );

  task automatic chk(input string tag,
                     input logic [SW-1:0] got,
                     input logic [SW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [30:0] madd(input logic [30:0] a,
                                       input logic [30:0] b);
    logic [31:0] t;
    t = {1'b0, a} + {1'b0, b};
    return (t >= P) ? 31'(t - P) : t[30:0];
  endfunction

  function automatic logic [30:0] mmul(input logic [30:0] a,
                                       input logic [30:0] b);
    logic [61:0] t;
    t = {31'b0, a} * {31'b0, b};
    return 31'(t % {30'b0, P});
  endfunction

  function automatic logic [30:0] rc_fn(input int r, input bit z);
    logic [31:0] t;
    t = (32'(r) * 32'h9E37_79B9) ^ 32'h0123_4567;
    return z ? 31'd0 : 31'(t % P);
  endfunction

  // One partial round: add constant and x^5 on lane 0, then diag + sum mix.
  function automatic logic [SW-1:0] pr_fn(input logic [SW-1:0] s,
                                          input logic [30:0] c);
    logic [30:0] e [W];
    logic [30:0] x, x2, x4, sum;
    logic [SW-1:0] r;
    for (int i = 0; i < W; i++) e[i] = s[31*i +: 31];
    x  = madd(e[0], c);
    x2 = mmul(x, x);
    x4 = mmul(x2, x2);
    e[0] = mmul(x4, x);
    sum = '0;
    for (int i = 0; i < W; i++) sum = madd(sum, e[i]);
    for (int i = 0; i < W; i++)
      e[i] = madd(mmul(e[i], 31'(i + 2)), sum);
    for (int i = 0; i < W; i++) r[31*i +: 31] = e[i];
    return r;
  endfunction

  function automatic logic [SW-1:0] golden(input logic [SW-1:0] s,
                                           input bit z);
    logic [SW-1:0] t;
    t = s;
    for (int r = 0; r < NR; r++) t = pr_fn(t, rc_fn(r, z));
    return t;
  endfunction

  assign rc_i = rc_fn(int'(rc_idx_o), zero_rc);

  logic [SW-1:0] pipe [PL];
  always @(posedge clk) begin
    pipe[0] <= pr_fn(dp_state_o, dp_const_o);
    for (int k = 1; k < PL; k++) pipe[k] <= pipe[k-1];
  end
  assign dp_state_i = pipe[PL-1];

  logic [SW-1:0] exp_q [$];
  int due_q [$];
  int idx_q [$];
  int idx_cyc [$];
  int last_acc = -1;
  int last_ohs = -1;
  bit ov_prev = 0;
  bit busy_prev = 0;
  int idx_prev = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid_i && in_ready_o) begin
        exp_q.push_back(golden(in_state_i, zero_rc));
        due_q.push_back(cyc + LAT);
        last_acc = cyc;
      end
      if (out_valid_o && !ov_prev) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          chk("out_state", out_state_o, exp_q.pop_front());
          chk("out_cycle", SW'(cyc), SW'(due_q.pop_front()));
        end
      end
      if (out_valid_o && out_ready_i) last_ohs = cyc;
      if (busy_o && (!busy_prev || int'(rc_idx_o) != idx_prev)) begin
        idx_q.push_back(int'(rc_idx_o));
        idx_cyc.push_back(cyc);
      end
    end
    ov_prev   = out_valid_o;
    busy_prev = busy_o;
    idx_prev  = int'(rc_idx_o);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] s);
    int n;
    bit hs;
    n = 0;
    hs = 0;
    in_state_i = s;
    in_valid_i = 1;
    while (!hs && n < 600) begin
      @(negedge clk);
      hs = in_ready_o;
      n++;
    end
    tick();
    in_valid_i = 0;
    if (!hs) chk("in_timeout", 0, 1);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid_o && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_o) chk("out_timeout", 0, 1);
  endtask

  task automatic flush();
    exp_q.delete();
    due_q.delete();
  endtask

  logic [SW-1:0] s_a, s_b, hold_st;

  initial begin
    for (int i = 0; i < W; i++) s_a[31*i +: 31] = 31'(i);
    for (int i = 0; i < W; i++) s_b[31*i +: 31] = 31'(100 * i + 7);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_state", out_state_o, 0);
    chk("rst_round", round_o, 0);

    // All-zero job accepted at cycle 10.
    zero_rc = 1;
    while (cyc < 10) tick();
    send('0);
    chk("acc_cycle10", last_acc, 10);
    wait_out();
    chk("zero_state", out_state_o, 0);
    tick();

    // Known state 0..15 with nonzero constants; track the round indices.
    zero_rc = 0;
    idx_q.delete();
    idx_cyc.delete();
    send(s_a);
    wait_out();
    tick();
    chk("idx_count", idx_q.size(), NR);
    if (idx_q.size() == NR) begin
      chk("idx0_cycle", idx_cyc[0], last_acc + 1);
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("idx%0d", k), idx_q[k], k);
        if (k > 0)
          chk($sformatf("gap%0d", k), idx_cyc[k] - idx_cyc[k-1], PL + 1);
      end
    end

    // Backpressure in DONE with a second job waiting.
    out_ready_i = 0;
    send(s_b);
    wait_out();
    hold_st = out_state_o;
    tick();
    in_state_i = s_a;
    in_valid_i = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid_o, 1);
      chk("hold_state", out_state_o, hold_st);
      chk("hold_in_ready", in_ready_o, 0);
    end
    tick();
    out_ready_i = 1;
    tick();
    @(negedge clk);
    tick();
    in_valid_i = 0;
    chk("acc_after_ohs", last_acc, last_ohs + 1);
    wait_out();
    tick();

    // Reset during round 5 WAIT.
    send(s_b);
    for (int n = 0; n < 600 && round_o != 5; n++) @(negedge clk);
    chk("reach_round5", round_o, 5);
    repeat (4) @(negedge clk);
    #1;
    rst_n = 0;
    flush();
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("mrst_in_ready", in_ready_o, 1);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_out_valid", out_valid_o, 0);
    chk("mrst_round", round_o, 0);
    tick();
    send(s_a);
    wait_out();
    tick();

`ifdef M31_SCHED_ABORT_EN
    send(s_b);
    for (int n = 0; n < 600 && round_o != 3; n++) @(negedge clk);
    repeat (4) @(negedge clk);
    #1;
    abort_i = 1;
    flush();
    tick();
    abort_i = 0;
    @(negedge clk);
    chk("abort_in_ready", in_ready_o, 1);
    chk("abort_out_valid", out_valid_o, 0);
    repeat (250) @(negedge clk);
    tick();
    send(s_b);
    wait_out();
    tick();
`endif

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/m31_partial_round_sched.md
Name: m31_partial_round_sched

Overview:
- Iterative sequencer that runs one Poseidon2 state through N_ROUNDS partial rounds.
- Uses a single shared, fully-pipelined M31 partial-round datapath; datapath latency is PR_LATENCY cycles.
- Accepts a state over a valid/ready handshake, issues one round at a time, and fetches each round's constant by index from an external constant ROM.
- Captures each datapath result after a fixed latency and returns the final state over a valid/ready handshake. Sits between the permutation top-level and the partial-round datapath.

Parameters:
- WIDTH, 16, state width in M31 elements (16 or 24).
- N_ROUNDS, 14, partial rounds per job (>=1).
- PR_LATENCY, 13, clk edges from datapath input sampling to valid datapath output (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid_i  in  1  input state valid
- in_ready_o  out  1  scheduler can accept a job
- in_state_i  in  WIDTH*31  input state; element i at bits [31i+30:31i]
- rc_idx_o  out  max(1,$clog2(N_ROUNDS))  constant ROM index (= current round)
- rc_i  in  31  round constant for rc_idx_o, combinational same-cycle
- dp_state_o  out  WIDTH*31  to datapath state_i
- dp_const_o  out  31  to datapath const_i
- dp_state_i  in  WIDTH*31  from datapath state_o
- out_valid_o  out  1  final state valid
- out_ready_i  in  1  downstream accepts final state
- out_state_o  out  WIDTH*31  final state
- busy_o  out  1  high in any state other than IDLE
- round_o  out  max(1,$clog2(N_ROUNDS))  current round number

Behaviour:
- Internal registers: WIDTH*31 work register, round counter, latency counter cnt (width $clog2(PR_LATENCY)+1).
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o: work <= in_state_i; round <= 0; next state ISSUE.
- ISSUE (exactly 1 cycle):
  - The datapath samples dp_state_o and dp_const_o at the end of this cycle.
  - cnt <= PR_LATENCY-1; next state WAIT.
- WAIT:
  - If cnt != 0: cnt decrements.
  - If cnt == 0: work <= dp_state_i (valid this cycle: PR_LATENCY edges after ISSUE).
    - If round == N_ROUNDS-1: next state DONE.
    - Else: round increments; next state ISSUE.
- DONE:
  - out_valid_o=1, out_state_o=work.
  - On out_ready_i: next state IDLE.
  - out_state_o must stay stable while out_valid_o is high and out_ready_i is low.
- Continuous drives:
  - dp_state_o = work at all times.
  - dp_const_o = rc_i at all times.
  - rc_idx_o = round_o = round.
  - Datapath outputs are ignored in every cycle except the WAIT capture cycle.
- Timing:
  - Cycles per round = PR_LATENCY+1.
  - Handshake at cycle a gives out_valid_o first high at cycle a+1+N_ROUNDS*(PR_LATENCY+1).
  - Defaults: a+197.
- No overlap between jobs: in_ready_o=0 in ISSUE, WAIT and DONE. After the DONE->IDLE transition, a new job can be accepted the following cycle.
- Reset values: state IDLE, work=0, round=0, cnt=0; out_valid_o=0, out_state_o=0, busy_o=0, in_ready_o=1.
- Reset asserted mid-job: the job is dropped with no output; IDLE on the cycle after reset is released.
- Both handshakes are registered-state based. in_valid_i presented while the scheduler is not in IDLE is held off, not lost, provided the upstream holds it.

Optional Feature:
- Macro: M31_SCHED_ABORT_EN.
- When defined:
  - Adds input port abort_i (1 bit).
  - abort_i high in ISSUE, WAIT or DONE forces next state IDLE and drops the job; out_valid_o is low from the next cycle.
  - Abort has priority over capture and the out handshake in the same cycle.
  - abort_i is ignored in IDLE.
- When undefined: no port, no abort logic.

Test Plan:
- All-zero state, all-zero constants, accepted at cycle 10 -> out_valid_o first high at cycle 207; out_state_o all zero.
- Known state 0..15, ROM with golden M31 constants, datapath model of latency 13 -> out_state_o matches the software golden model after 14 partial rounds.
- rc_idx_o monitor -> index r presented during exactly one ISSUE cycle for each r=0..13, in order, with exactly 13 WAIT cycles between consecutive ISSUE cycles.
- out_ready_i held low for 50 cycles in DONE -> out_valid_o stays 1, out_state_o stable, in_ready_o=0; second in_valid_i is accepted only on the cycle after the out handshake.
- rst_n low for 1 cycle during WAIT of round 5 -> next cycle IDLE with in_ready_o=1, busy_o=0, out_valid_o=0, round_o=0; a new job then completes with full latency.
- With M31_SCHED_ABORT_EN: abort_i pulsed in round 3 WAIT -> IDLE the next cycle, no out_valid_o pulse; a subsequent job yields the correct result.
